// File: rtl/microcode_sequencer.sv
// microcode_sequencer: walks the microstep counter for the current opcode,
// addresses the registered microcode ROM, and presents the (jump-masked)
// control word for exactly one EXEC cycle per microstep. Each microstep is an
// ADDR cycle (ROM read in flight) followed by an EXEC cycle (word applied).
module microcode_sequencer #(
    parameter int         MAX_STEPS = 5,
    parameter int         HLT_BIT   = 15,
    parameter int         J_BIT     = 1,
    parameter logic [3:0] JC_OPCODE = 4'h7,
    parameter logic [3:0] JZ_OPCODE = 4'h8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        carry,
    input  logic        zero,
    input  logic        run,
    input  logic        step_req,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] ctrl,
    output logic [3:0]  step,
    output logic        instr_done,
    output logic        halted
);

    localparam logic [3:0] LAST_STEP = 4'(MAX_STEPS - 1);

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] w;
    logic        j_block;
    logic        advance;
    logic        last_step;

    assign advance = run | step_req;

    // Conditional jumps: drop the PC-load bit when the tested flag is clear.
    always_comb begin
        j_block = ((opcode == JC_OPCODE) && !carry) ||
                  ((opcode == JZ_OPCODE) && !zero);
        w = rom_data;
        if (j_block) begin
            w[J_BIT] = 1'b0;
        end
    end

    // The fetch steps (0 and 1) always run even when their word is zero;
    // after that an all-zero word means the instruction has nothing left to do.
    assign last_step = (step_q == LAST_STEP) ||
                       ((step_q >= 4'd2) && (w == 16'h0000));

    // Next-state and output decode; outputs are zero outside EXEC.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        ctrl       = 16'h0000;
        instr_done = 1'b0;
        case (state_q)
            S_ADDR: begin
                // The ROM address was stable for this whole cycle, so the
                // registered ROM output is valid once we reach EXEC.
                if (advance) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ctrl = w;
                if (w[HLT_BIT]) begin
                    state_d = S_HALT;
                end else if (last_step) begin
                    instr_done = 1'b1;
                    step_d     = 4'd0;
                    state_d    = S_ADDR;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = S_ADDR;
                end
            end
            S_HALT: begin
                // Sticky until reset; all inputs ignored.
                state_d = S_HALT;
            end
            default: begin
                state_d = S_ADDR;
                step_d  = 4'd0;
            end
        endcase
    end

    // State and microstep registers; reset drops straight back to ADDR/step 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ADDR;
            step_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    assign rom_addr = {opcode, step_q};
    assign step     = step_q;
    assign halted   = (state_q == S_HALT);

endmodule
